// File: rtl/ascensor_ctrl.sv
// SCAN elevator controller driving motor/door and a shared external 4-bit Counter used as its only timer.
// Optional door-hold input when DOOR_HOLD_EN is defined. Registered state/outputs; counter handshake is combinational on cnt_q.
module ascensor_ctrl #(
    parameter int NFLOORS      = 4,
    parameter int FW           = 2,
    parameter int TRAVEL_TICKS = 8,
    parameter int DOOR_TICKS   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NFLOORS-1:0] req,
`ifdef DOOR_HOLD_EN
    input  logic               door_hold,
`endif
    output logic               cnt_enb,
    output logic               cnt_modo,
    output logic [3:0]         cnt_data,
    input  logic [3:0]         cnt_q,
    output logic [FW-1:0]      floor,
    output logic               motor_up,
    output logic               motor_dn,
    output logic               door_open,
    output logic               busy
);

    if (TRAVEL_TICKS < 1 || TRAVEL_TICKS > 15) begin : g_bad_travel
        $error("ascensor_ctrl: TRAVEL_TICKS must be in 1..15");
    end
    if (DOOR_TICKS < 1 || DOOR_TICKS > 15) begin : g_bad_door
        $error("ascensor_ctrl: DOOR_TICKS must be in 1..15");
    end
    if ((2 ** FW) < NFLOORS) begin : g_bad_fw
        $error("ascensor_ctrl: FW too narrow for NFLOORS");
    end

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MOVE_UP,
        MOVE_DN,
        DOOR_OPEN
    } state_t;

    localparam logic [3:0] TLIM = 4'(TRAVEL_TICKS);
    localparam logic [3:0] DLIM = 4'(DOOR_TICKS);

    state_t             state;
    state_t             nxt;
    logic               dir_up;
    logic               first;
    logic [NFLOORS-1:0] pend;
    logic [NFLOORS-1:0] pend_nxt;
    logic               timed;
    logic               hold;
    logic               expire;
    logic [3:0]         lim;
    logic               here;
    logic               above;
    logic               below;

`ifdef DOOR_HOLD_EN
    assign hold = door_hold && (state == DOOR_OPEN);
`else
    assign hold = 1'b0;
`endif

    // The counter keeps its last value between timed states, so a stale
    // Q==LIM on the load cycle must not count as expiry.
    assign timed    = (state == MOVE_UP) || (state == MOVE_DN) || (state == DOOR_OPEN);
    assign lim      = (state == DOOR_OPEN) ? DLIM : TLIM;
    assign cnt_modo = timed && (first || hold);
    assign expire   = timed && !cnt_modo && (cnt_q == lim);
    assign cnt_enb  = timed && !expire;
    assign cnt_data = 4'd0;

    always_comb begin
        here  = 1'b0;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (pend[i] && (i == int'(floor))) here  = 1'b1;
            if (pend[i] && (i >  int'(floor))) above = 1'b1;
            if (pend[i] && (i <  int'(floor))) below = 1'b1;
        end
    end

    always_comb begin
        pend_nxt = pend | req;
        if (state == DOOR_OPEN) begin
            for (int i = 0; i < NFLOORS; i++) begin
                if (i == int'(floor)) pend_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (|pend) nxt = CHECK;
            end
            CHECK: begin
                if (here)                 nxt = DOOR_OPEN;
                else if (dir_up && above)  nxt = MOVE_UP;
                else if (dir_up && below)  nxt = MOVE_DN;
                else if (!dir_up && below) nxt = MOVE_DN;
                else if (!dir_up && above) nxt = MOVE_UP;
                else                       nxt = IDLE;
            end
            MOVE_UP, MOVE_DN, DOOR_OPEN: begin
                if (expire) nxt = CHECK;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            floor     <= '0;
            dir_up    <= 1'b1;
            pend      <= '0;
            first     <= 1'b0;
            motor_up  <= 1'b0;
            motor_dn  <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            pend      <= pend_nxt;
            first     <= ((state == CHECK) && (nxt != IDLE)) || hold;
            motor_up  <= (nxt == MOVE_UP);
            motor_dn  <= (nxt == MOVE_DN);
            door_open <= (nxt == DOOR_OPEN);
            busy      <= (nxt != IDLE);
            if (state == CHECK && nxt == MOVE_UP) dir_up <= 1'b1;
            if (state == CHECK && nxt == MOVE_DN) dir_up <= 1'b0;
            if (state == MOVE_UP && expire) floor <= floor + FW'(1);
            if (state == MOVE_DN && expire) floor <= floor - FW'(1);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (int'(floor) < NFLOORS)
                else $error("ascensor_ctrl: floor above top floor");
            assert (!(state == MOVE_UP && int'(floor) == NFLOORS - 1))
                else $error("ascensor_ctrl: moving up from top floor");
            assert (!(state == MOVE_DN && floor == '0))
                else $error("ascensor_ctrl: moving down from floor 0");
        end
    end
`endif

endmodule
